// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbiter: state encoding, default byte width and
// the width helper for the busy-wait counter.
package uart_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitBusy = 2'd1,
        StWaitDone = 2'd2
    } arb_state_e;

    // Counter must hold values up to timeout-1; never narrower than one bit.
    function automatic int unsigned timeout_cnt_w(int unsigned timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first set request at or after the pointer, wrapping.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic               o_valid,
    output logic [ID_W-1:0]    o_index
);

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        o_valid = 1'b0;
        o_index = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (i_req[(int'(i_ptr) + off) % NUM_REQ]) begin
                o_valid = 1'b1;
                o_index = ID_W'((int'(i_ptr) + off) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte sources.
// Define UART_ARB_BURST_EN to let an owner send up to MAX_BURST consecutive bytes.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned  NUM_REQ      = 4,
    parameter int unsigned  DATA_W       = DEFAULT_DATA_W,
    parameter int unsigned  BUSY_TIMEOUT = 16,
    parameter int unsigned  MAX_BURST    = 4,
    localparam int unsigned ID_W         = $clog2(NUM_REQ)
) (
    input  logic                      clk1,
    input  logic                      ret1,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      tx_wr,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [ID_W-1:0]           active_id,
    output logic                      idle,
    output logic                      err_timeout
);

    localparam int unsigned CNT_W = timeout_cnt_w(BUSY_TIMEOUT);

    arb_state_e          r_state, w_state_next;
    logic [ID_W-1:0]     r_ptr, w_ptr_next;
    logic [ID_W-1:0]     r_active_id, w_active_id_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic [NUM_REQ-1:0]  r_gnt, w_gnt_next;
    logic                r_tx_wr, w_tx_wr_next;
    logic [DATA_W-1:0]   r_tx_data, w_tx_data_next;
    logic                r_err, w_err_next;
    logic                w_pick_valid;
    logic [ID_W-1:0]     w_pick_idx;
    logic [ID_W-1:0]     w_ptr_after;

`ifdef UART_ARB_BURST_EN
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
    logic [BURST_W-1:0]  r_burst, w_burst_next;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_picker (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_valid),
        .o_index (w_pick_idx)
    );

    assign w_ptr_after = (r_active_id == ID_W'(NUM_REQ - 1)) ? '0 : r_active_id + 1'b1;

    always_comb begin
        w_state_next     = r_state;
        w_ptr_next       = r_ptr;
        w_active_id_next = r_active_id;
        w_cnt_next       = r_cnt;
        w_gnt_next       = '0;
        w_tx_wr_next     = 1'b0;
        w_tx_data_next   = r_tx_data;
        w_err_next       = r_err;
`ifdef UART_ARB_BURST_EN
        w_burst_next     = r_burst;
`endif
        unique case (r_state)
            StIdle: begin
                // A busy transmitter in IDLE belongs to someone else; do not arbitrate.
                if (!tx_busy && w_pick_valid) begin
                    w_gnt_next       = NUM_REQ'(1) << w_pick_idx;
                    w_tx_wr_next     = 1'b1;
                    w_tx_data_next   = req_data[w_pick_idx * DATA_W +: DATA_W];
                    w_active_id_next = w_pick_idx;
                    w_cnt_next       = '0;
                    w_state_next     = StWaitBusy;
`ifdef UART_ARB_BURST_EN
                    if (w_pick_idx == r_active_id && r_burst != '0 &&
                        r_burst < BURST_W'(MAX_BURST)) begin
                        w_burst_next = r_burst + 1'b1;
                    end else begin
                        w_burst_next = BURST_W'(1);
                    end
                end else if (req == '0) begin
                    w_burst_next = '0;
`endif
                end
            end
            StWaitBusy: begin
                if (tx_busy) begin
                    w_state_next = StWaitDone;
                end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    w_err_next   = 1'b1;
                    w_state_next = StIdle;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    w_state_next = StIdle;
                    w_ptr_next   = w_ptr_after;
`ifdef UART_ARB_BURST_EN
                    // Parking the pointer on the owner makes the picker re-grant it.
                    if (req[r_active_id] && r_burst < BURST_W'(MAX_BURST)) begin
                        w_ptr_next = r_active_id;
                    end
`endif
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge ret1) begin
        if (!ret1) begin
            r_state     <= StIdle;
            r_ptr       <= '0;
            r_active_id <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_tx_wr     <= 1'b0;
            r_tx_data   <= '0;
            r_err       <= 1'b0;
`ifdef UART_ARB_BURST_EN
            r_burst     <= '0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_active_id <= w_active_id_next;
            r_cnt       <= w_cnt_next;
            r_gnt       <= w_gnt_next;
            r_tx_wr     <= w_tx_wr_next;
            r_tx_data   <= w_tx_data_next;
            r_err       <= w_err_next;
`ifdef UART_ARB_BURST_EN
            r_burst     <= w_burst_next;
`endif
        end
    end

    assign gnt         = r_gnt;
    assign tx_wr       = r_tx_wr;
    assign tx_data     = r_tx_data;
    assign active_id   = r_active_id;
    assign idle        = (r_state == StIdle);
    assign err_timeout = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester and transmitter models drive the DUT,
// expected (owner, byte) pairs are queued at stimulus time and checked at each tx_wr.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int FRAME   = 10;

    logic                      clk1 = 1'b0;
    logic                      ret1 = 1'b0;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        gnt;
    logic                      tx_wr;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_busy;
    logic [1:0]                active_id;
    logic                      idle;
    logic                      err_timeout;

    int          rem [NUM_REQ];
    logic [7:0]  dat [NUM_REQ];
    int          exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_strobes = 0;
    int          n_frames = 0;
    bit          mute = 1'b0;
    logic        r_model_busy = 1'b0;
    logic        r_ext_busy = 1'b0;
    int          dly = 0;
    int          frame_left = 0;
    logic [7:0]  last_data = '0;

    assign tx_busy = r_model_busy | r_ext_busy;

    always #5 clk1 = ~clk1;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_W       (DATA_W),
        .BUSY_TIMEOUT (16),
        .MAX_BURST    (4)
    ) dut (
        .clk1        (clk1),
        .ret1        (ret1),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .tx_wr       (tx_wr),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .active_id   (active_id),
        .idle        (idle),
        .err_timeout (err_timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push_exp(input int id, input logic [7:0] d);
        exp_q.push_back(id * 256 + int'(d));
    endfunction

    function automatic bit rem_pending();
        for (int i = 0; i < NUM_REQ; i++) if (rem[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Scoreboard, requester model and transmitter model, all sampled on the falling edge.
    always @(negedge clk1) begin
        int e;
        if (ret1) begin
            if (tx_wr) begin
                n_strobes++;
                check_eq("busy_at_wr", tx_busy, 0);
                check_eq("wr_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("tx_data", tx_data, e % 256);
                    check_eq("gnt", gnt, 1 << (e / 256));
                    check_eq("active_id", active_id, e / 256);
                end
                last_data = tx_data;
                for (int i = 0; i < NUM_REQ; i++) if (gnt[i] && rem[i] > 0) rem[i]--;
                if (!mute) dly = 3;
            end else if (gnt != '0) begin
                check_eq("gnt_without_wr", tx_wr, 1);
            end
            if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    r_model_busy = 1'b1;
                    frame_left   = FRAME;
                end
            end else if (frame_left > 0) begin
                frame_left--;
                if (frame_left == 0) begin
                    r_model_busy = 1'b0;
                    n_frames++;
                    check_eq("tx_data_hold", tx_data, last_data);
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i] = (rem[i] > 0);
            req_data[i*DATA_W +: DATA_W] = dat[i];
        end
    end

    task automatic do_reset();
        ret1 = 1'b0;
        r_model_busy = 1'b0;
        dly = 0;
        frame_left = 0;
        for (int i = 0; i < NUM_REQ; i++) rem[i] = 0;
        repeat (2) @(posedge clk1);
        #2 ret1 = 1'b1;
    endtask

    task automatic wait_wr(output int n);
        n = 0;
        do begin
            @(negedge clk1);
            n++;
        end while (!tx_wr && n < 50);
    endtask

    task automatic wait_quiet(input string tag);
        int n = 0;
        while (!(idle && !tx_busy && exp_q.size() == 0 && !rem_pending()) && n < 600) begin
            @(negedge clk1);
            n++;
        end
        check_eq(tag, n < 600, 1);
    endtask

    initial begin
        int n, s, f;
        for (int i = 0; i < NUM_REQ; i++) begin
            rem[i] = 0;
            dat[i] = '0;
        end
        ret1 = 1'b0;
        #12;
        check_eq("rst_idle", idle, 1);
        check_eq("rst_gnt", gnt, 0);
        check_eq("rst_tx_wr", tx_wr, 0);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_active_id", active_id, 0);
        check_eq("rst_err", err_timeout, 0);
        @(posedge clk1);
        #2 ret1 = 1'b1;

        // Single requester.
        @(posedge clk1);
        #2 dat[2] = 8'h75; rem[2] = 1; push_exp(2, 8'h75);
        @(negedge clk1);
        wait_wr(n);
        check_eq("single_latency", n, 1);
        wait_quiet("single_done");
        check_eq("single_idle", idle, 1);

        // Reset while the frame is in flight.
        @(posedge clk1);
        #2 dat[1] = 8'h5A; rem[1] = 1; push_exp(1, 8'h5A);
        n = 0;
        while (!tx_busy && n < 50) begin
            @(negedge clk1);
            n++;
        end
        check_eq("mid_busy_seen", tx_busy, 1);
        @(posedge clk1);
        #2 ret1 = 1'b0;
        r_model_busy = 1'b0;
        dly = 0;
        frame_left = 0;
        #1;
        check_eq("mid_rst_idle", idle, 1);
        check_eq("mid_rst_gnt", gnt, 0);
        check_eq("mid_rst_tx_wr", tx_wr, 0);
        check_eq("mid_rst_tx_data", tx_data, 0);
        check_eq("mid_rst_active_id", active_id, 0);
        s = n_strobes;
        repeat (3) @(negedge clk1);
        @(posedge clk1);
        #2 ret1 = 1'b1;
        repeat (5) @(negedge clk1);
        check_eq("mid_rst_no_gnt", n_strobes, s);
        check_eq("mid_rst_still_idle", idle, 1);

        // All four requesters; requester 0 has two bytes queued.
        s = n_strobes;
        f = n_frames;
        @(posedge clk1);
        #2;
        for (int i = 0; i < NUM_REQ; i++) begin
            dat[i] = 8'h10 + 8'(i);
            rem[i] = (i == 0) ? 2 : 1;
        end
`ifdef UART_ARB_BURST_EN
        push_exp(0, 8'h10); push_exp(0, 8'h10);
        push_exp(1, 8'h11); push_exp(2, 8'h12); push_exp(3, 8'h13);
`else
        push_exp(0, 8'h10); push_exp(1, 8'h11); push_exp(2, 8'h12);
        push_exp(3, 8'h13); push_exp(0, 8'h10);
`endif
        wait_quiet("rr_done");
        check_eq("rr_strobes", n_strobes - s, 5);
        check_eq("rr_frames", n_frames - f, 5);

        // Transmitter never answers.
        @(posedge clk1);
        #2 mute = 1'b1; dat[1] = 8'hC3; rem[1] = 1; push_exp(1, 8'hC3);
        wait_wr(n);
        n = 0;
        while (!err_timeout && n < 40) begin
            @(negedge clk1);
            n++;
        end
        check_eq("timeout_cycles", n, 16);
        check_eq("timeout_idle", idle, 1);
        mute = 1'b0;
        @(posedge clk1);
        #2 dat[3] = 8'h3C; rem[3] = 1; push_exp(3, 8'h3C);
        @(negedge clk1);
        wait_wr(n);
        check_eq("after_timeout_latency", n, 1);
        wait_quiet("after_timeout_done");
        check_eq("err_sticky", err_timeout, 1);

        // Transmitter owned externally.
        s = n_strobes;
        @(posedge clk1);
        #2 r_ext_busy = 1'b1; dat[0] = 8'hA5; rem[0] = 1; push_exp(0, 8'hA5);
        repeat (8) @(negedge clk1);
        check_eq("ext_busy_hold", n_strobes, s);
        check_eq("ext_busy_idle", idle, 1);
        @(negedge clk1);
        r_ext_busy = 1'b0;
        wait_wr(n);
        check_eq("ext_busy_release", n, 1);
        wait_quiet("ext_busy_done");

        // Two persistent requesters from a fresh pointer.
        do_reset();
        check_eq("err_cleared", err_timeout, 0);
        @(posedge clk1);
        #2 dat[0] = 8'h40; dat[1] = 8'h41; rem[0] = 4; rem[1] = 2;
`ifdef UART_ARB_BURST_EN
        push_exp(0, 8'h40); push_exp(0, 8'h40); push_exp(0, 8'h40); push_exp(0, 8'h40);
        push_exp(1, 8'h41); push_exp(1, 8'h41);
`else
        push_exp(0, 8'h40); push_exp(1, 8'h41); push_exp(0, 8'h40);
        push_exp(1, 8'h41); push_exp(0, 8'h40); push_exp(0, 8'h40);
`endif
        wait_quiet("pair_done");
        check_eq("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
